// File: rtl/display_mux8.sv
// Eight-digit multiplexed 7-segment driver with per-digit enable, blink and anti-ghost gap.
// One-cycle registered outputs; no backpressure, the scan free-runs every cycle.
module display_mux8 #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int SCAN_HZ    = 8000,
    parameter int GAP        = 1,
    parameter int BLINK_HZ   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] digits,
    input  logic [7:0]  blink,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp
);
    localparam int DIV = CLOCK_FREQ / SCAN_HZ;
    localparam int BH  = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = (BH > 1) ? $clog2(BH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    dig [8];
    logic [5:0]    cur;
    logic          blank;

    for (genvar k = 0; k < 8; k++) begin : g_dig
        assign dig[k] = digits[6*k +: 6];
    end

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1111111;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BW'(BH - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end

        // Inputs are sampled live, not latched at slot start.
        cur   = dig[idx_q];
        blank = (int'(cnt_q) < GAP) || !cur[5] || (blink[idx_q] && phase_q);
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (!blank) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = {seg7(cur[4:1]), ~cur[0]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an      = an_q;
    assign dec_ddp = seg_q;
endmodule

// File: tb/tb_display_mux8.sv
// Bench for display_mux8: directed and random digit/blink patterns against an edge-count reference model.
module tb_display_mux8;
    localparam int CF  = 80;
    localparam int SH  = 8;
    localparam int GP  = 1;
    localparam int BHZ = 2;
    localparam int DIV = CF / SH;
    localparam int BH  = CF / (2 * BHZ);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] digits = '0;
    logic [7:0]  blink = '0;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [6:0] segtab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    display_mux8 #(.CLOCK_FREQ(CF), .SCAN_HZ(SH), .GAP(GP), .BLINK_HZ(BHZ)) dut (
        .clock   (clock),
        .reset   (reset),
        .digits  (digits),
        .blink   (blink),
        .an      (an),
        .dec_ddp (dec_ddp)
    );

    always #5 clock = ~clock;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Edge n after reset release shows what the scan position at edge n-1 selects.
    task automatic tick();
        int c, ix, ph;
        logic [5:0] d;
        logic [7:0] ea, ed;
        @(posedge clock);
        n++;
        c  = (n - 1) % DIV;
        ix = ((n - 1) / DIV) % 8;
        ph = ((n - 1) / BH) % 2;
        d  = digits[ix*6 +: 6];
        if (c < GP || !d[5] || (blink[ix] && ph == 1)) begin
            ea = 8'hFF;
            ed = 8'hFF;
        end else begin
            ea = ~(8'd1 << ix);
            ed = {segtab[d[4:1]], ~d[0]};
        end
        #1;
        check8("an", an, ea);
        check8("dec_ddp", dec_ddp, ed);
        total++;
        assert ($countones(~an) <= 1) else begin
            bad++;
            $error("FAIL an_onehot: observed=%h expected at most one zero bit", an);
        end
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        // Reset state
        for (int k = 0; k < 8; k++) digits[k*6 +: 6] = {1'b1, 4'(k), 1'b0};
        repeat (2) @(posedge clock);
        #1;
        check8("reset_an", an, 8'hFF);
        check8("reset_dec_ddp", dec_ddp, 8'hFF);
        #1 reset = 1'b0;
        n = 0;

        // Counting pattern, full sweep plus wrap
        ticks(90);

        // Digit 3 = 8 with dp, others 0; then digit 3 disabled
        for (int k = 0; k < 8; k++) digits[k*6 +: 6] = 6'b100000;
        digits[3*6 +: 6] = {1'b1, 4'h8, 1'b1};
        ticks(80);
        digits[3*6 +: 6] = {1'b0, 4'h8, 1'b1};
        ticks(80);

        // Blink digit 0 showing 1
        for (int k = 0; k < 8; k++) digits[k*6 +: 6] = {1'b1, 4'(k), 1'b0};
        digits[5:0] = {1'b1, 4'h1, 1'b0};
        blink = 8'h01;
        ticks(160);

        // Random patterns changing mid-slot
        for (int r = 0; r < 60; r++) begin
            digits[47:16] = $urandom();
            digits[15:0]  = 16'($urandom());
            blink         = 8'($urandom());
            ticks($urandom_range(1, 15));
        end

        // All hex values on digit 0
        blink = 8'h00;
        for (int v = 0; v < 16; v++) begin
            digits[5:0] = {1'b1, 4'(v), 1'b0};
            ticks(80);
        end

        // Asynchronous reset in the middle of slot 5
        for (int k = 0; k < 8; k++) digits[k*6 +: 6] = {1'b1, 4'(k), 1'b0};
        begin
            int guard;
            guard = 0;
            tick();
            while (!(((n - 1) / DIV) % 8 == 5 && (n - 1) % DIV == 4) && guard < 200) begin
                tick();
                guard++;
            end
            total++;
            assert (guard < 200) else begin
                bad++;
                $error("FAIL slot5_reach: observed guard=%0d expected < 200", guard);
            end
        end
        check8("pre_reset_an", an, 8'hDF);
        check8("pre_reset_dec_ddp", dec_ddp, {segtab[5], 1'b1});
        #2 reset = 1'b1;
        #1;
        check8("async_reset_an", an, 8'hFF);
        check8("async_reset_dec_ddp", dec_ddp, 8'hFF);
        @(posedge clock);
        #1;
        check8("held_reset_an", an, 8'hFF);
        reset = 1'b0;
        n = 0;
        ticks(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
